stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch control stage sitting directly downstream of the one-second timer. Consumes the timer's `second_elapsed` strobe, accumulates elapsed time as four BCD digits (MM:SS), and drives the timer's `enable`/`clear` inputs from user start/stop, lap and clear commands. Outputs feed the seven-segment display driver.

## Interface
- `MIN_TENS_MAX`, default 5: highest value of the minutes-tens digit. The count wraps after `MIN_TENS_MAX`9:59.
- `clk` input 1: system clock, rising edge.
- `async_nreset` input 1: asynchronous, active-low reset.
- `start_stop` input 1: single-cycle command pulse, already debounced.
- `lap` input 1: single-cycle command pulse, already debounced.
- `clear` input 1: single-cycle command pulse, already debounced.
- `second_elapsed` input 1: strobe from the timer.
- `timer_enable` output 1: drives the timer `enable`.
- `timer_clear` output 1: drives the timer `clear`.
- `sec_ones` output 4: displayed seconds-ones digit, BCD 0–9.
- `sec_tens` output 4: displayed seconds-tens digit, BCD 0–5.
- `min_ones` output 4: displayed minutes-ones digit, BCD 0–9.
- `min_tens` output 4: displayed minutes-tens digit, BCD 0–`MIN_TENS_MAX`.
- `running` output 1: high in RUN and LAP.
- `lap_active` output 1: high in LAP.
- `wrap` output 1: one-cycle pulse when the count rolls over to 00:00.

## Operation
- FSM states are IDLE, RUN, PAUSE and LAP.
- IDLE:
  - `start_stop` -> RUN.
- RUN:
  - `start_stop` -> PAUSE.
  - `lap` -> LAP, and the current live digits are latched into the lap register.
- LAP: live count keeps advancing; the outputs show the lap register.
  - `lap` -> RUN, and the outputs return to the live digits.
  - `start_stop` -> PAUSE, and the outputs return to the live digits.
- PAUSE:
  - `start_stop` -> RUN.
  - `lap` is ignored.
- `clear` in any state -> IDLE. Live digits, lap register, edge detector and `wrap` are zeroed on the same edge.
- Simultaneous commands: priority is `clear` > `start_stop` > `lap`; lower-priority pulses in that cycle are dropped.
- `timer_enable` = state is RUN or LAP (combinational from the state register).
- `timer_clear` = state is IDLE. This holds the timer at zero whenever the stopwatch is idle.
- Tick detection:
  - tick = `second_elapsed` & ~`se_d`, where `se_d` is a one-cycle registered copy of `second_elapsed`.
  - A held-high strobe therefore counts exactly once.
  - Ticks are counted only in RUN or LAP; ticks in IDLE or PAUSE are discarded.
- BCD chain:
  - `sec_ones` increments on a tick.
  - Each digit carries into the next when it is at its maximum and incrementing; maxima are 9, 5, 9, `MIN_TENS_MAX`.
  - A digit at its maximum with carry-in goes to 0.
  - At `MIN_TENS_MAX`9:59, a tick produces 00:00 and `wrap`=1 for one cycle.
- A tick in the same cycle as a `clear` is dropped; `clear` wins.
- A tick in the same cycle as a `lap` entering LAP: the pre-increment value is latched, and the live count still increments.

## Timing
- Reset values, asynchronous on `async_nreset` low:
  - state IDLE; all digits 0; lap register 0; `se_d` 0.
  - `wrap` 0, `running` 0, `lap_active` 0, `timer_enable` 0, `timer_clear` 1.
- Command latency: a pulse sampled at edge k changes the state after edge k. `timer_enable`, `timer_clear`, `running` and `lap_active` reflect the new state in cycle k+1.
- Tick latency:
  - Cycle N has `second_elapsed`=1 and `se_d`=0.
  - Digits update at the edge ending cycle N and are visible in cycle N+1.
  - `wrap` is high in cycle N+1 only.
- Display outputs are registered; there is no combinational path from inputs to digit outputs.
- Reset asserted mid-count returns everything to the reset values immediately; the first command after reset release is honoured normally.

## Structure
- Package `stopwatch_pkg`:
  - FSM state encoding (2-bit, localparams).
  - Counter control codes NONE=0, INCR=1, LOAD=2, CLR=3, shared with the existing register primitive.
  - BCD digit maxima constants.
- Sub-module `bcd_digit`:
  - Parameter `MAX`.
  - Inputs `clk`, `async_nreset`, `inc`, `clr`; outputs `value[3:0]`, `carry` (= `inc` & `value`==`MAX`).
  - Instantiated four times and chained by `carry`.
- Top level holds the FSM, edge detector, lap register, output mux and `wrap` register.

## Test plan
- Reset then idle: hold `second_elapsed` pulses for 10 s -> digits stay 00:00, `timer_clear`=1, `timer_enable`=0.
- `start_stop`, then 75 ticks (each `second_elapsed` high one cycle in four) -> display 01:15, `running`=1; `second_elapsed` held high 5 cycles counts once.
- Run to 01:15, `lap`, 10 more ticks -> outputs frozen at 01:15, `lap_active`=1; second `lap` -> display 01:25.
- Preload to 59:59 via 3599 ticks, one more tick -> 00:00 with `wrap` high exactly one cycle.
- `start_stop` at 00:07 -> PAUSE; 5 ticks ignored (00:07); `start_stop` plus 1 tick -> 00:08.
- `clear`+`start_stop`+tick in the same cycle while in RUN at 00:30 -> IDLE, 00:00, no increment; `async_nreset` pulse in LAP -> all reset values.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  // Counter control codes, matching the existing register primitive.
  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_INCR = 2'd1,
    CTRL_LOAD = 2'd2,
    CTRL_CLR  = 2'd3
  } ctrl_e;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam int unsigned MIN_TENS_MAX_DEFAULT = 5;

  // Clear dominates increment.
  function automatic ctrl_e digit_ctrl(input logic inc, input logic clr);
    if (clr)      return CTRL_CLR;
    else if (inc) return CTRL_INCR;
    else          return CTRL_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the elapsed-time chain; wraps to 0 after MAX.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc & (value == MAX);

  // Digit register: clear, increment with wrap, or hold.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      value <= '0;
    end else begin
      case (digit_ctrl(inc, clr))
        CTRL_CLR:  value <= '0;
        CTRL_INCR: value <= (value == MAX) ? '0 : value + 4'd1;
        default:   value <= value;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: command FSM, tick edge detect, BCD MM:SS count,
// lap freeze register and timer enable/clear drive.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       second_elapsed,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  state_e     state;
  logic       se_d;
  logic       counting;
  logic       tick;
  logic [3:0] live_so, live_st, live_mo, live_mt;
  logic [3:0] lap_so, lap_st, lap_mo, lap_mt;
  logic       c_so, c_st, c_mo, c_mt;

  assign counting     = (state == ST_RUN) || (state == ST_LAP);
  assign timer_enable = counting;
  assign running      = counting;
  assign lap_active   = (state == ST_LAP);
  assign timer_clear  = (state == ST_IDLE);

  // A clear in the same cycle swallows the tick.
  assign tick = second_elapsed & ~se_d & counting & ~clear;

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .async_nreset(async_nreset), .inc(tick), .clr(clear),
    .value(live_so), .carry(c_so)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .async_nreset(async_nreset), .inc(c_so), .clr(clear),
    .value(live_st), .carry(c_st)
  );
  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk(clk), .async_nreset(async_nreset), .inc(c_st), .clr(clear),
    .value(live_mo), .carry(c_mo)
  );
  bcd_digit #(.MAX(4'(MIN_TENS_MAX))) u_min_tens (
    .clk(clk), .async_nreset(async_nreset), .inc(c_mo), .clr(clear),
    .value(live_mt), .carry(c_mt)
  );

  // Command FSM with clear > start_stop > lap priority.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else if (start_stop) begin
      case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   state <= ST_PAUSE;
        ST_LAP:   state <= ST_PAUSE;
        default:  state <= ST_RUN;
      endcase
    end else if (lap) begin
      case (state)
        ST_RUN:  state <= ST_LAP;
        ST_LAP:  state <= ST_RUN;
        default: state <= state;
      endcase
    end
  end

  // Second-strobe edge detector history, zeroed by clear.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset)  se_d <= 1'b0;
    else if (clear)     se_d <= 1'b0;
    else                se_d <= second_elapsed;
  end

  // Lap register captures the pre-increment live value on entry to LAP.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      {lap_mt, lap_mo, lap_st, lap_so} <= '0;
    end else if (clear) begin
      {lap_mt, lap_mo, lap_st, lap_so} <= '0;
    end else if ((state == ST_RUN) && lap && !start_stop) begin
      {lap_mt, lap_mo, lap_st, lap_so} <= {live_mt, live_mo, live_st, live_so};
    end
  end

  // Rollover pulse: carry out of the top digit.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) wrap <= 1'b0;
    else               wrap <= c_mt & ~clear;
  end

  // Display mux between live count and frozen lap value.
  always_comb begin
    {min_tens, min_ones, sec_tens, sec_ones} = {live_mt, live_mo, live_st, live_so};
    if (state == ST_LAP) begin
      {min_tens, min_ones, sec_tens, sec_ones} = {lap_mt, lap_mo, lap_st, lap_so};
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against a seconds-count model.
module tb_stopwatch_ctrl;

  localparam int MTMAX = 5;
  localparam int MODV  = 600 * (MTMAX + 1);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk;
  logic       async_nreset;
  logic       start_stop, lap, clear, second_elapsed;
  logic       timer_enable, timer_clear, running, lap_active, wrap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

  int n_checks;
  int n_errors;

  // model state
  int m_mode;
  int m_secs;
  int m_lapsecs;
  bit m_sed;
  bit m_wrap;

  stopwatch_ctrl #(.MIN_TENS_MAX(MTMAX)) dut (
    .clk(clk), .async_nreset(async_nreset),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .second_elapsed(second_elapsed),
    .timer_enable(timer_enable), .timer_clear(timer_clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_disp(input int s);
    logic [15:0] d;
    d[15:12] = 4'(s / 600);
    d[11:8]  = 4'((s / 60) % 10);
    d[7:4]   = 4'((s / 10) % 6);
    d[3:0]   = 4'(s % 10);
    return d;
  endfunction

  function automatic logic [15:0] dut_disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_secs = 0; m_lapsecs = 0; m_sed = 0; m_wrap = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step(input bit ss, input bit lp, input bit cl, input bit se);
    bit counting;
    bit tk;
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    tk = se && !m_sed && counting;
    if (cl) begin
      model_reset();
    end else begin
      m_sed  = se;
      m_wrap = tk && (m_secs == MODV - 1);
      if (ss) begin
        if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
        else                                       m_mode = M_PAUSE;
      end else if (lp) begin
        if (m_mode == M_RUN) begin
          m_lapsecs = m_secs;
          m_mode = M_LAP;
        end else if (m_mode == M_LAP) begin
          m_mode = M_RUN;
        end
      end
      if (tk) m_secs = (m_secs + 1) % MODV;
    end
  endtask

  task automatic check_all(input string tag);
    bit cnt;
    cnt = (m_mode == M_RUN) || (m_mode == M_LAP);
    check({tag, ".disp"}, 32'(dut_disp()), 32'(to_disp(m_mode == M_LAP ? m_lapsecs : m_secs)));
    check({tag, ".run"},  32'(running),      32'(cnt));
    check({tag, ".en"},   32'(timer_enable), 32'(cnt));
    check({tag, ".tclr"}, 32'(timer_clear),  32'(m_mode == M_IDLE));
    check({tag, ".lapa"}, 32'(lap_active),   32'(m_mode == M_LAP));
    check({tag, ".wrap"}, 32'(wrap),         32'(m_wrap));
  endtask

  // One clock cycle with the given command/strobe inputs.
  task automatic cyc(input bit ss, input bit lp, input bit cl, input bit se, input string tag);
    start_stop = ss; lap = lp; clear = cl; second_elapsed = se;
    @(posedge clk);
    model_step(ss, lp, cl, se);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 1, tag);
      cyc(0, 0, 0, 0, tag);
      cyc(0, 0, 0, 0, tag);
      cyc(0, 0, 0, 0, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    async_nreset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    start_stop = 0; lap = 0; clear = 0; second_elapsed = 0;
    @(negedge clk);
    async_nreset = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, ".rel"});
  endtask

  int wrap_count;

  initial begin
    n_checks = 0; n_errors = 0;
    start_stop = 0; lap = 0; clear = 0; second_elapsed = 0;
    async_nreset = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    async_nreset = 1'b1;
    @(posedge clk); #1;

    // idle: strobes are discarded
    ticks(10, "idle");
    check("idle_disp", 32'(dut_disp()), 32'h0000);
    check("idle_tclr", 32'(timer_clear), 32'd1);
    check("idle_en", 32'(timer_enable), 32'd0);

    // run 75 s
    cyc(1, 0, 0, 0, "start");
    ticks(75, "run75");
    check("run75_disp", 32'(dut_disp()), 32'h0115);
    check("run75_run", 32'(running), 32'd1);

    // lap freeze, 10 ticks, lap release
    cyc(0, 1, 0, 0, "lap_on");
    ticks(10, "lapping");
    check("lap_frozen", 32'(dut_disp()), 32'h0115);
    check("lap_active", 32'(lap_active), 32'd1);
    cyc(0, 1, 0, 0, "lap_off");
    check("lap_release", 32'(dut_disp()), 32'h0125);

    // held-high strobe counts once
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, "held");
    cyc(0, 0, 0, 0, "held");
    check("held_once", 32'(dut_disp()), 32'h0126);

    // lap coincident with tick: pre-increment value latched
    cyc(0, 1, 0, 1, "lap_tick");
    cyc(0, 0, 0, 0, "lap_tick");
    check("lap_tick_frz", 32'(dut_disp()), 32'h0126);
    cyc(1, 0, 0, 0, "lap_to_pause");
    check("lap_pause_live", 32'(dut_disp()), 32'h0127);
    cyc(0, 1, 0, 0, "pause_lap_ign");
    check("pause_lap_ign", 32'(lap_active), 32'd0);

    // wrap from 59:59
    cyc(0, 0, 1, 0, "clr");
    cyc(1, 0, 0, 0, "start2");
    ticks(3599, "to5959");
    check("at5959", 32'(dut_disp()), 32'h5959);
    wrap_count = 0;
    cyc(0, 0, 0, 1, "wrapedge");
    for (int i = 0; i < 4; i++) begin
      if (wrap) wrap_count++;
      cyc(0, 0, 0, 0, "wrapafter");
    end
    check("wrap_disp", 32'(dut_disp()), 32'h0000);
    check("wrap_once", 32'(wrap_count), 32'd1);

    // pause at 00:07
    ticks(7, "to07");
    cyc(1, 0, 0, 0, "pause");
    ticks(5, "paused");
    check("paused_disp", 32'(dut_disp()), 32'h0007);
    cyc(1, 0, 0, 0, "resume");
    ticks(1, "resume_tick");
    check("resume_disp", 32'(dut_disp()), 32'h0008);

    // clear + start_stop + tick together at 00:30
    ticks(22, "to30");
    check("at30", 32'(dut_disp()), 32'h0030);
    cyc(1, 0, 1, 1, "clr_combo");
    check("combo_disp", 32'(dut_disp()), 32'h0000);
    check("combo_tclr", 32'(timer_clear), 32'd1);
    cyc(0, 0, 0, 0, "clr_combo2");

    // async reset in LAP
    cyc(1, 0, 0, 0, "start3");
    ticks(3, "pre_lap");
    cyc(0, 1, 0, 0, "lap3");
    do_reset("rst_lap");
    check("rst_lapa", 32'(lap_active), 32'd0);
    cyc(1, 0, 0, 0, "post_rst_start");
    check("post_rst_run", 32'(running), 32'd1);

    // randomized commands and strobes
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
